// File: rtl/irq_controller.sv
// irq_controller: synchronises and edge-detects raw interrupt lines, latches
// them as pending (irw), arbitrates by fixed priority (line N-1 highest) and
// runs a req/id/ack handshake to the CPU, tracking in-service levels (isr)
// until eret.
// Optional feature macro: IRQ_NEST_EN (priority nesting / preemption).
module irq_controller #(
  parameter int N   = 3,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic           ie,
  input  logic           ack,
  input  logic           eret,
  output logic           irq_req,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   irw,
  output logic [N-1:0]   isr
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N-1:0]     sync1_q, sync2_q, prev_q;
  logic [N-1:0]     irw_q, irw_d;
  logic [N-1:0]     isr_q, isr_d;
  logic [N-1:0]     rise, id_oh, eret_clr;
  logic [IDW-1:0]   cand, isr_top;
  logic             elig, take;

  // Index of the highest set bit (0 when the vector is empty).
  function automatic logic [IDW-1:0] top_idx(input logic [N-1:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) r = IDW'(i);
    return r;
  endfunction

  // One-hot mask of the highest set bit.
  function automatic logic [N-1:0] top_oh(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    return r;
  endfunction

  // Two-flop synchroniser followed by a previous-value register for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise    = sync2_q & ~prev_q;
  assign cand    = top_idx(irw_q);
  assign isr_top = top_idx(isr_q);
  assign id_oh   = {{(N-1){1'b0}}, 1'b1} << id_q;

`ifdef IRQ_NEST_EN
  // A strictly higher line than the current in-service level may preempt.
  assign elig     = ie && (|irw_q) && ((isr_q == '0) || (cand > isr_top));
  assign eret_clr = eret ? top_oh(isr_q) : '0;
`else
  // Only one handler at a time; eret ends it completely.
  assign elig     = ie && (|irw_q) && (isr_q == '0);
  assign eret_clr = eret ? {N{1'b1}} : '0;
`endif

  // Handshake FSM: next state, id capture and the ack "take" strobe.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    take    = 1'b0;
    case (state_q)
      IDLE: if (elig) begin
        state_d = REQ;
        id_d    = cand;
      end
      REQ: begin
        if (ack) begin
          take    = 1'b1;
          state_d = IDLE;
        end else if (!ie) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending set wins over ack clear; in-service takes eret clear then ack set.
  always_comb begin
    irw_d = (irw_q & ~(take ? id_oh : '0)) | rise;
    isr_d = (isr_q & ~eret_clr) | (take ? id_oh : '0);
  end

  // State, id, pending and in-service registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      irw_q   <= '0;
      isr_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      irw_q   <= irw_d;
      isr_q   <= isr_d;
    end
  end

  assign irq_req = (state_q == REQ);
  assign irq_id  = id_q;
  assign irw     = irw_q;
  assign isr     = isr_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (N=3). Inputs change 1ns after a rising
// edge; outputs are sampled at the same point. A rise driven just after
// edge 0 shows in irw after edge 3 and as a request after edge 4.
module tb_irq_controller;
  localparam int N   = 3;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   irq_in;
  logic           ie, ack, eret;
  logic           irq_req;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   irw, isr;

  int n_chk = 0;
  int n_err = 0;

  irq_controller #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .ie(ie), .ack(ack), .eret(eret),
    .irq_req(irq_req), .irq_id(irq_id), .irw(irw), .isr(isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Handshake status in one go.
  task automatic st(input string tag, input logic req, input logic [IDW-1:0] id,
                    input logic [N-1:0] w, input logic [N-1:0] s);
    chk({tag, ".req"}, 32'(irq_req), 32'(req));
    if (req) chk({tag, ".id"}, 32'(irq_id), 32'(id));
    chk({tag, ".irw"}, 32'(irw), 32'(w));
    chk({tag, ".isr"}, 32'(isr), 32'(s));
  endtask

  task automatic pulse_ack(input logic with_eret);
    ack = 1'b1; eret = with_eret;
    tick();
    ack = 1'b0; eret = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; ie = 1'b1; ack = 1'b0; eret = 1'b0;
    #12;
    st("reset", 1'b0, 3'd0, 3'b000, 3'b000);
    chk("reset.id", 32'(irq_id), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);

    // ack in IDLE must be ignored
    pulse_ack(1'b0);
    st("idle_ack", 1'b0, 3'd0, 3'b000, 3'b000);

    // basic handshake on line 1 (edge 0 = the edge just passed)
    irq_in = 3'b010;
    tick(2);
    st("basic.e2", 1'b0, 3'd0, 3'b000, 3'b000);
    tick();
    st("basic.e3", 1'b0, 3'd0, 3'b010, 3'b000);
    tick();
    st("basic.e4", 1'b1, 3'd1, 3'b010, 3'b000);
    pulse_ack(1'b0);
    st("basic.ack", 1'b0, 3'd0, 3'b000, 3'b010);
    irq_in = '0;
    pulse_eret();
    st("basic.eret", 1'b0, 3'd0, 3'b000, 3'b000);
    tick(3);

    // priority: lines 0 and 2 together
    irq_in = 3'b101;
    tick(4);
    st("prio.first", 1'b1, 3'd2, 3'b101, 3'b000);
    pulse_ack(1'b0);
    st("prio.ack", 1'b0, 3'd0, 3'b001, 3'b100);
    tick(3);
    st("prio.blocked", 1'b0, 3'd0, 3'b001, 3'b100);
    pulse_eret();
    st("prio.eret", 1'b0, 3'd0, 3'b001, 3'b000);
    tick();
    st("prio.second", 1'b1, 3'd0, 3'b001, 3'b000);
    pulse_ack(1'b0);
    st("prio.ack2", 1'b0, 3'd0, 3'b000, 3'b001);
    irq_in = '0;
    pulse_eret();
    st("prio.eret2", 1'b0, 3'd0, 3'b000, 3'b000);
    tick(3);

    // enable gating, then a re-rise on line 1 coinciding with its ack
    irq_in = 3'b010;
    tick(4);
    st("ie.req", 1'b1, 3'd1, 3'b010, 3'b000);
    ie = 1'b0;
    tick();
    st("ie.off", 1'b0, 3'd0, 3'b010, 3'b000);
    tick();
    st("ie.off2", 1'b0, 3'd0, 3'b010, 3'b000);
    ie = 1'b1;
    tick();
    st("ie.on", 1'b1, 3'd1, 3'b010, 3'b000);
    irq_in = '0;             // low seen from the next edge on
    tick();
    irq_in = 3'b010;         // new rise, detected in irw at edge +3
    tick(2);
    pulse_ack(1'b0);
    st("simul.ack", 1'b0, 3'd0, 3'b010, 3'b010);
    pulse_eret();
    st("simul.eret", 1'b0, 3'd0, 3'b010, 3'b000);
    tick();
    st("simul.req2", 1'b1, 3'd1, 3'b010, 3'b000);
    pulse_ack(1'b0);
    st("simul.ack2", 1'b0, 3'd0, 3'b000, 3'b010);
    irq_in = '0;
    pulse_eret();
    tick(3);

    // nesting behaviour: isr=001, then line 2 rises
    irq_in = 3'b001;
    tick(4);
    st("nest.req0", 1'b1, 3'd0, 3'b001, 3'b000);
    pulse_ack(1'b0);
    st("nest.ack0", 1'b0, 3'd0, 3'b000, 3'b001);
    irq_in = 3'b100;
    tick(4);
`ifdef IRQ_NEST_EN
    st("nest.pre", 1'b1, 3'd2, 3'b100, 3'b001);
    pulse_ack(1'b0);
    st("nest.ack2", 1'b0, 3'd0, 3'b000, 3'b101);
    pulse_eret();
    st("nest.eret", 1'b0, 3'd0, 3'b000, 3'b001);
    pulse_eret();
    st("nest.eret2", 1'b0, 3'd0, 3'b000, 3'b000);
    irq_in = '0;
    tick(3);
    // ack and eret together: isr=001, id=2 -> isr=100
    irq_in = 3'b001;
    tick(4);
    pulse_ack(1'b0);
    irq_in = 3'b100;
    tick(4);
    st("both.req", 1'b1, 3'd2, 3'b100, 3'b001);
    pulse_ack(1'b1);
    st("both.isr", 1'b0, 3'd0, 3'b000, 3'b100);
    pulse_eret();
`else
    st("nest.blocked", 1'b0, 3'd0, 3'b100, 3'b001);
    pulse_eret();
    st("nest.eret", 1'b0, 3'd0, 3'b100, 3'b000);
    tick();
    st("nest.req2", 1'b1, 3'd2, 3'b100, 3'b000);
    // ack and eret together with isr=0: eret ignored, isr = one-hot id
    pulse_ack(1'b1);
    st("both.isr", 1'b0, 3'd0, 3'b000, 3'b100);
    pulse_eret();
    st("both.eret", 1'b0, 3'd0, 3'b000, 3'b000);
`endif
    irq_in = '0;
    tick(3);

    // asynchronous reset in the middle of a request
    irq_in = 3'b101;
    tick(4);
    st("rst.pre", 1'b1, 3'd2, 3'b101, 3'b000);
    #3;
    rst = 1'b0;
    #1;
    st("rst.async", 1'b0, 3'd0, 3'b000, 3'b000);
    chk("rst.async.id", 32'(irq_id), 32'd0);
    irq_in = '0;
    tick(2);
    rst = 1'b1;
    tick(5);
    st("rst.after", 1'b0, 3'd0, 3'b000, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
